ni_traffic_node: RTL and testbench
==================================

Name: ni_traffic_node

Overview:
- Parametrised network-interface node: a traffic generator (TX) plus a checking receiver (RX) for one router port of the NoC.
- TX emits a programmable number of sequence-numbered, parity-protected packets to a runtime-selected destination, with a valid/busy handshake and a configurable inter-packet gap.
- RX accepts packets addressed to this node, checks parity and sequence order, and counts them. Used for link bring-up and loopback tests.

Parameters:
- PKT_COUNT, 500, number of packets per TX run (1..2^PL_SZ-1).
- GAP, 4, idle cycles between an accepted packet and the next req (0 allowed).
- HDR_VAL, 0, constant value of the HDR_SZ-1 header field.
- LED_DIV, 64, led toggles every LED_DIV packets received, and once per completed TX run.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- id  in  ADDR_SZ  this node's address
- dest_cfg  in  ADDR_SZ  TX destination, sampled on start
- start  in  1  one-cycle pulse that begins a TX run; ignored while busy
- item_out  out  HDR_SZ+PL_SZ+ADDR_SZ  TX packet {parity, header, payload, dest}
- req  out  1  TX packet valid
- channel_busy  in  1  router back-pressure
- item_in  in  HDR_SZ+PL_SZ+ADDR_SZ  RX packet
- valid  in  1  RX packet strobe, one cycle per packet
- busy  out  1  TX run in progress
- done  out  1  one-cycle pulse when the last packet of a run is accepted
- tx_count  out  PL_SZ  packets accepted in the current or last run
- rx_count  out  PL_SZ  packets received with a good address, wraps modulo 2^PL_SZ
- parity_err  out  1  sticky RX parity error
- seq_err  out  1  sticky RX sequence error
- led  out  1  activity indicator

Behaviour:
- Reset (reset=0, asynchronous) drives every output to 0 and puts the TX FSM in IDLE. The RX expected sequence is 0 and the sticky flags are cleared. If reset arrives mid-run, the run is aborted and nothing resumes after reset.
- Packet format:
  - dest = latched dest_cfg.
  - payload = sequence number, 0..PKT_COUNT-1.
  - header = HDR_VAL.
  - MSB = XOR of all lower bits (even parity over the whole word).
- TX FSM states: IDLE, SEND, GAP.
  - IDLE: on start=1, latch dest_cfg, seq=0, tx_count=0, busy=1, go to SEND.
    - In the same edge, load item_out and set req=1. First req is visible 1 cycle after start.
  - SEND: req=1 and item_out are held stable until an edge where channel_busy=0. That edge is the acceptance.
    - On acceptance: tx_count+1 and req=0.
    - If seq==PKT_COUNT-1: pulse done, busy=0, toggle led, go to IDLE.
    - Else if GAP=0: load seq+1 and keep req=1 (back-to-back packets).
    - Else: go to GAP.
  - GAP: count GAP cycles with req=0, then load the next packet and assert req, go to SEND.
  - start while busy=1 is ignored.
- RX: acts on valid=1 only.
  - Address filter: item_in[ADDR_SZ-1:0]==id. If it does not match, drop the packet; no counters or flags change.
  - Parity: XOR of the full word ≠ 0 → parity_err=1, packet discarded, expected sequence unchanged.
  - Sequence: if parity is good and payload ≠ expected, seq_err=1 and expected resynchronises to payload+1. Otherwise expected+1.
  - rx_count+1 for every address-matched packet with good parity. led toggles when rx_count reaches a multiple of LED_DIV.
  - A payload of 0 with good parity always resynchronises expected to 1 without flagging an error, so a new run is accepted.
- Simultaneous events:
  - TX done and an RX-driven led toggle in the same cycle cancel each other; led does not change.
  - TX and RX are otherwise independent and may be active in the same cycle.
- Widths: counters are PL_SZ bits, and arithmetic is modulo 2^PL_SZ. PKT_COUNT ≥ 2^PL_SZ is illegal and is caught by an elaboration check.
- No $display in synthesised paths.

Decomposition:
- Shared constants include file holds ADDR_SZ, PL_SZ and HDR_SZ, plus field-offset macros PAR_BIT, HDR_LSB and PL_LSB.
- One sub-module, ni_rx_checker, contains the address filter, parity and sequence checks, rx_count and the sticky flags.
- The TX FSM stays in the top level.

Test Plan:
- Reset mid-run: start with dest_cfg=1 and PKT_COUNT=8; drop reset after 3 accepts → all outputs 0 within the same cycle, and busy stays 0 after reset until a new start.
- Free channel: channel_busy=0, GAP=4, PKT_COUNT=8 → 8 packets with payloads 0..7, req high 1 cycle each, 4-cycle gaps, done pulse on the 8th accept, tx_count=8.
- Back-pressure: hold channel_busy=1 for 5 cycles during packet 2 → item_out and req stay stable; payload 2 is accepted on the first free cycle, with no duplicates and no skips.
- Loopback: item_out wired to item_in, req to valid, id=dest_cfg=3 → rx_count=8, parity_err=0, seq_err=0.
- Parity fault: inject a packet with its MSB flipped → parity_err=1, rx_count unchanged; the following good packet raises no seq_err.
- Sequence and address: deliver payloads 0,1,3 to id=3 → seq_err=1 and expected becomes 4. A packet with dest=2 is ignored entirely.

Source files
------------

// File: rtl/ni_traffic_node_pkg.sv
// Shared widths, packet field offsets and packet helpers for the NoC
// traffic node (TX generator + RX checker).
package ni_traffic_node_pkg;

   localparam int ADDR_SZ = 4;
   localparam int PL_SZ   = 10;
   localparam int HDR_SZ  = 2;

   // Packet word: {parity, header[HDR_SZ-2:0], payload[PL_SZ-1:0], dest[ADDR_SZ-1:0]}
   localparam int PKT_W   = HDR_SZ + PL_SZ + ADDR_SZ;
   localparam int PAR_BIT = PKT_W - 1;
   localparam int HDR_LSB = PL_SZ + ADDR_SZ;
   localparam int PL_LSB  = ADDR_SZ;

   localparam logic [ADDR_SZ-1:0] ADDR_ZERO = {ADDR_SZ{1'b0}};
   localparam logic [PL_SZ-1:0]   PL_ZERO   = {PL_SZ{1'b0}};
   localparam logic [PL_SZ-1:0]   PL_ONE    = {{(PL_SZ-1){1'b0}}, 1'b1};
   localparam logic [PKT_W-1:0]   PKT_ZERO  = {PKT_W{1'b0}};

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_GAP  = 2'd2
   } tx_state_e;

   // Assemble a packet and set the MSB so the whole word has even parity.
   function automatic logic [PKT_W-1:0] pkt_build(
      input logic [HDR_SZ-2:0]  hdr,
      input logic [PL_SZ-1:0]   pl,
      input logic [ADDR_SZ-1:0] dest
   );
      logic [PKT_W-2:0] body;
      body = {hdr, pl, dest};
      return {^body, body};
   endfunction

   // True when the full word, parity bit included, XORs to zero.
   function automatic logic pkt_parity_ok(input logic [PKT_W-1:0] word);
      return ~(^word);
   endfunction

endpackage

// File: rtl/ni_traffic_node_rx_checker.sv
// Receive side of the traffic node: address filter, parity check,
// sequence tracking, received-packet counter and sticky error flags.
module ni_rx_checker
   import ni_traffic_node_pkg::*;
#(
   parameter int LED_DIV = 64
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [ADDR_SZ-1:0] id_i,
   input  logic [PKT_W-1:0]   item_i,
   input  logic               valid_i,
   output logic [PL_SZ-1:0]   rx_count_o,
   output logic               parity_err_o,
   output logic               seq_err_o,
   output logic               led_tick_o
);

   logic [PL_SZ-1:0] cnt_q, cnt_d;
   logic [PL_SZ-1:0] exp_q, exp_d;
   logic             par_err_q, par_err_d;
   logic             seq_err_q, seq_err_d;

   logic             hit_s;
   logic             par_ok_s;
   logic [PL_SZ-1:0] pl_s;
   logic [PL_SZ-1:0] cnt_nxt_s;

   assign hit_s     = valid_i && (item_i[ADDR_SZ-1:0] == id_i);
   assign par_ok_s  = pkt_parity_ok(item_i);
   assign pl_s      = item_i[PL_LSB +: PL_SZ];
   assign cnt_nxt_s = cnt_q + PL_ONE;

   // Decide counter, expected-sequence and flag updates for the current strobe.
   always_comb begin
      cnt_d      = cnt_q;
      exp_d      = exp_q;
      par_err_d  = par_err_q;
      seq_err_d  = seq_err_q;
      led_tick_o = 1'b0;
      if (hit_s) begin
         if (!par_ok_s) begin
            // Corrupted packet is dropped; expected sequence is left alone.
            par_err_d = 1'b1;
         end else begin
            cnt_d      = cnt_nxt_s;
            led_tick_o = ((32'(cnt_nxt_s) % 32'(LED_DIV)) == 32'd0);
            if (pl_s == PL_ZERO) begin
               // Payload 0 marks the start of a new run: resync silently.
               exp_d = PL_ONE;
            end else if (pl_s != exp_q) begin
               seq_err_d = 1'b1;
               exp_d     = pl_s + PL_ONE;
            end else begin
               exp_d = exp_q + PL_ONE;
            end
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // RX state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= PL_ZERO;
         exp_q     <= PL_ZERO;
         par_err_q <= 1'b0;
         seq_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         exp_q     <= exp_d;
         par_err_q <= par_err_d;
         seq_err_q <= seq_err_d;
      end
   end

   assign rx_count_o   = cnt_q;
   assign parity_err_o = par_err_q;
   assign seq_err_o    = seq_err_q;

endmodule

// File: rtl/ni_traffic_node.sv
// NoC network-interface traffic node: TX packet generator with valid/busy
// handshake and inter-packet gap, plus an RX checker for loopback tests.
module ni_traffic_node
   import ni_traffic_node_pkg::*;
#(
   parameter int                PKT_COUNT = 500,
   parameter int                GAP       = 4,
   parameter logic [HDR_SZ-2:0] HDR_VAL   = {(HDR_SZ-1){1'b0}},
   parameter int                LED_DIV   = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_SZ-1:0] id,
   input  logic [ADDR_SZ-1:0] dest_cfg,
   input  logic               start,
   output logic [PKT_W-1:0]   item_out,
   output logic               req,
   input  logic               channel_busy,
   input  logic [PKT_W-1:0]   item_in,
   input  logic               valid,
   output logic               busy,
   output logic               done,
   output logic [PL_SZ-1:0]   tx_count,
   output logic [PL_SZ-1:0]   rx_count,
   output logic               parity_err,
   output logic               seq_err,
   output logic               led
);

   generate
      if (PKT_COUNT < 1 || PKT_COUNT >= (1 << PL_SZ)) begin : g_bad_pkt_count
         $error("PKT_COUNT must lie in 1..2**PL_SZ-1");
      end
      if (GAP < 0 || LED_DIV < 1) begin : g_bad_timing
         $error("GAP must be >= 0 and LED_DIV >= 1");
      end
   endgenerate

   localparam int                 GAP_W       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0]   GAP_ZERO    = GAP_W'(0);
   localparam logic [GAP_W-1:0]   GAP_ONE     = GAP_W'(1);
   localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [PL_SZ-1:0]   SEQ_LAST    = PL_SZ'(PKT_COUNT - 1);
   localparam logic               BACK2BACK   = (GAP == 0);

   tx_state_e          state_q, state_d;
   logic [ADDR_SZ-1:0] dest_q, dest_d;
   logic [PL_SZ-1:0]   seq_q, seq_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [PKT_W-1:0]   item_q, item_d;
   logic               req_q, req_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [PL_SZ-1:0]   tx_cnt_q, tx_cnt_d;
   logic               led_q, led_d;

   logic               accept_s;
   logic               last_s;
   logic [PL_SZ-1:0]   seq_nxt_s;
   logic               rx_tick_s;

   assign accept_s  = (state_q == TX_SEND) && !channel_busy;
   assign last_s    = (seq_q == SEQ_LAST);
   assign seq_nxt_s = seq_q + PL_ONE;

   // TX sequencer state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= TX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // TX sequencer next-state decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         TX_IDLE: begin
            if (start) state_d = TX_SEND;
            else       state_d = TX_IDLE;
         end
         TX_SEND: begin
            if (!accept_s)     state_d = TX_SEND;
            else if (last_s)   state_d = TX_IDLE;
            else if (BACK2BACK) state_d = TX_SEND;
            else               state_d = TX_GAP;
         end
         TX_GAP: begin
            if (gap_q == GAP_LAST) state_d = TX_SEND;
            else                   state_d = TX_GAP;
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // TX datapath next values: packet word, handshake, counters and led.
   always_comb begin
      dest_d   = dest_q;
      seq_d    = seq_q;
      gap_d    = gap_q;
      item_d   = item_q;
      req_d    = req_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      tx_cnt_d = tx_cnt_q;
      case (state_q)
         TX_IDLE: begin
            if (start) begin
               dest_d   = dest_cfg;
               seq_d    = PL_ZERO;
               tx_cnt_d = PL_ZERO;
               busy_d   = 1'b1;
               item_d   = pkt_build(HDR_VAL, PL_ZERO, dest_cfg);
               req_d    = 1'b1;
            end else begin
               req_d  = 1'b0;
               busy_d = 1'b0;
            end
         end
         TX_SEND: begin
            if (accept_s) begin
               tx_cnt_d = tx_cnt_q + PL_ONE;
               req_d    = 1'b0;
               gap_d    = GAP_ZERO;
               if (last_s) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end else if (BACK2BACK) begin
                  seq_d  = seq_nxt_s;
                  item_d = pkt_build(HDR_VAL, seq_nxt_s, dest_q);
                  req_d  = 1'b1;
               end else begin
                  seq_d = seq_q;
               end
            end else begin
               // Back-pressure: hold the offered packet unchanged.
               req_d = 1'b1;
            end
         end
         TX_GAP: begin
            if (gap_q == GAP_LAST) begin
               seq_d  = seq_nxt_s;
               item_d = pkt_build(HDR_VAL, seq_nxt_s, dest_q);
               req_d  = 1'b1;
            end else begin
               gap_d = gap_q + GAP_ONE;
            end
         end
         default: begin
            req_d  = 1'b0;
            busy_d = 1'b0;
         end
      endcase
      // A run completion and an RX milestone in the same cycle cancel out.
      led_d = led_q ^ done_d ^ rx_tick_s;
   end

   // TX datapath and activity-indicator registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dest_q   <= ADDR_ZERO;
         seq_q    <= PL_ZERO;
         gap_q    <= GAP_ZERO;
         item_q   <= PKT_ZERO;
         req_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         tx_cnt_q <= PL_ZERO;
         led_q    <= 1'b0;
      end else begin
         dest_q   <= dest_d;
         seq_q    <= seq_d;
         gap_q    <= gap_d;
         item_q   <= item_d;
         req_q    <= req_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         tx_cnt_q <= tx_cnt_d;
         led_q    <= led_d;
      end
   end

   ni_rx_checker #(
      .LED_DIV (LED_DIV)
   ) u_rx (
      .clk_i        (clk),
      .rst_ni       (reset),
      .id_i         (id),
      .item_i       (item_in),
      .valid_i      (valid),
      .rx_count_o   (rx_count),
      .parity_err_o (parity_err),
      .seq_err_o    (seq_err),
      .led_tick_o   (rx_tick_s)
   );

   assign item_out = item_q;
   assign req      = req_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign tx_count = tx_cnt_q;
   assign led      = led_q;

endmodule

// File: tb/tb_ni_traffic_node.sv
// Self-checking bench for ni_traffic_node: directed TX/RX scenarios with
// randomized back-pressure and RX traffic, checked against a rule-level model.
module tb_ni_traffic_node;
   import ni_traffic_node_pkg::*;

   localparam int                  NPKT  = 8;
   localparam int                  NGAP  = 4;
   localparam int                  LDIV  = 4;
   localparam logic [HDR_SZ-2:0]   HDR   = 1'b1;
   localparam int                  PMASK = (1 << PL_SZ) - 1;
   localparam logic [ADDR_SZ-1:0]  MY_ID = 4'd3;

   logic               clk = 1'b0;
   logic               reset;
   logic [ADDR_SZ-1:0] id;
   logic [ADDR_SZ-1:0] dest_cfg;
   logic               start;
   logic [PKT_W-1:0]   item_out;
   logic               req;
   logic               channel_busy;
   logic [PKT_W-1:0]   item_in;
   logic               valid;
   logic               busy;
   logic               done;
   logic [PL_SZ-1:0]   tx_count;
   logic [PL_SZ-1:0]   rx_count;
   logic               parity_err;
   logic               seq_err;
   logic               led;

   logic               lb;
   logic [PKT_W-1:0]   rx_item;
   logic               rx_valid;

   assign item_in = lb ? item_out : rx_item;
   assign valid   = lb ? (req & ~channel_busy) : rx_valid;

   always #5 clk = ~clk;

   ni_traffic_node #(
      .PKT_COUNT (NPKT),
      .GAP       (NGAP),
      .HDR_VAL   (HDR),
      .LED_DIV   (LDIV)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .id           (id),
      .dest_cfg     (dest_cfg),
      .start        (start),
      .item_out     (item_out),
      .req          (req),
      .channel_busy (channel_busy),
      .item_in      (item_in),
      .valid        (valid),
      .busy         (busy),
      .done         (done),
      .tx_count     (tx_count),
      .rx_count     (rx_count),
      .parity_err   (parity_err),
      .seq_err      (seq_err),
      .led          (led)
   );

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // Reference model state
   int m_cnt;
   int m_exp;
   bit m_par;
   bit m_seq;
   bit m_led;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PKT_W-1:0] mk(input int pl, input logic [ADDR_SZ-1:0] d);
      logic [PKT_W-2:0] b;
      b = {HDR, PL_SZ'(pl), d};
      return {^b, b};
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      m_exp = 0;
      m_par = 1'b0;
      m_seq = 1'b0;
      m_led = 1'b0;
   endtask

   // Apply the RX rules to one strobed word; tick reports an led milestone.
   task automatic rx_model(input logic [PKT_W-1:0] w, output bit tk);
      int pl;
      tk = 1'b0;
      if (w[ADDR_SZ-1:0] != MY_ID) begin
         tk = 1'b0;
      end else if (^w) begin
         m_par = 1'b1;
      end else begin
         pl    = int'(w[PL_LSB +: PL_SZ]);
         m_cnt = (m_cnt + 1) & PMASK;
         tk    = ((m_cnt % LDIV) == 0);
         if (pl == 0) begin
            m_exp = 1;
         end else if (pl != m_exp) begin
            m_seq = 1'b1;
            m_exp = (pl + 1) & PMASK;
         end else begin
            m_exp = (m_exp + 1) & PMASK;
         end
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_req"},      32'(req),        32'd0);
      chk({nm, "_busy"},     32'(busy),       32'd0);
      chk({nm, "_done"},     32'(done),       32'd0);
      chk({nm, "_item"},     32'(item_out),   32'd0);
      chk({nm, "_txcnt"},    32'(tx_count),   32'd0);
      chk({nm, "_rxcnt"},    32'(rx_count),   32'd0);
      chk({nm, "_parerr"},   32'(parity_err), 32'd0);
      chk({nm, "_seqerr"},   32'(seq_err),    32'd0);
      chk({nm, "_led"},      32'(led),        32'd0);
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      start        = 1'b0;
      channel_busy = 1'b0;
      rx_valid     = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      model_reset();
   endtask

   task automatic chk_rx(input string nm);
      chk({nm, "_rxcnt"},  32'(rx_count),   32'(m_cnt));
      chk({nm, "_parerr"}, 32'(parity_err), 32'(m_par));
      chk({nm, "_seqerr"}, 32'(seq_err),    32'(m_seq));
      chk({nm, "_led"},    32'(led),        32'(m_led));
   endtask

   task automatic send_rx(input logic [PKT_W-1:0] w, input string nm);
      bit tk;
      rx_item  = w;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_model(w, tk);
      m_led = m_led ^ tk;
      chk_rx(nm);
   endtask

   // One TX run: optional back-pressure hold on a packet, optional abort by reset.
   task automatic run_tx(input logic [ADDR_SZ-1:0] d, input int busy_pct,
                         input int hold_at, input int abort_at, input string nm);
      int acc;
      int cyc;
      int hold;
      int g;
      bit cb;
      bit tk;
      logic [PKT_W-1:0] w;
      acc  = 0;
      cyc  = 0;
      hold = 0;
      dest_cfg = d;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dest_cfg = ~d;
      chk({nm, "_busy_on"},  32'(busy),     32'd1);
      chk({nm, "_req_on"},   32'(req),      32'd1);
      chk({nm, "_txcnt0"},   32'(tx_count), 32'd0);
      while (acc < NPKT && cyc < 2000) begin
         if (abort_at >= 0 && acc == abort_at) begin
            #2 reset = 1'b0;
            #1;
            model_reset();
            chk_all_zero({nm, "_abort"});
            reset = 1'b1;
            for (int k = 0; k < 5; k++) begin
               tick();
               chk({nm, "_postabort_busy"}, 32'(busy), 32'd0);
               chk({nm, "_postabort_req"},  32'(req),  32'd0);
            end
            return;
         end
         chk({nm, "_item"}, 32'(item_out), 32'(mk(acc, d)));
         chk({nm, "_req"},  32'(req),      32'd1);
         if (acc == hold_at && hold < 5) begin
            cb = 1'b1;
            hold++;
         end else begin
            cb = (int'($urandom_range(99)) < busy_pct);
         end
         channel_busy = cb;
         start        = ($urandom_range(3) == 0);
         w            = item_out;
         tick();
         cyc++;
         start = 1'b0;
         if (!cb) begin
            acc++;
            tk = 1'b0;
            if (lb) rx_model(w, tk);
            if (acc == NPKT) m_led = m_led ^ 1'b1 ^ tk;
            else             m_led = m_led ^ tk;
            chk({nm, "_txcnt"}, 32'(tx_count), 32'(acc));
            chk({nm, "_done"},  32'(done),     32'(acc == NPKT));
            chk({nm, "_led"},   32'(led),      32'(m_led));
            if (acc < NPKT) begin
               g = 0;
               while (req === 1'b0 && g < NGAP + 3) begin
                  channel_busy = ($urandom_range(1) == 0);
                  tick();
                  cyc++;
                  g++;
               end
               chk({nm, "_gap"}, 32'(g), 32'(NGAP));
            end
         end
      end
      channel_busy = 1'b0;
      chk({nm, "_all_accepted"}, 32'(acc),      32'(NPKT));
      chk({nm, "_busy_off"},     32'(busy),     32'd0);
      chk({nm, "_req_off"},      32'(req),      32'd0);
      tick();
      chk({nm, "_done_pulse"},   32'(done),     32'd0);
      chk({nm, "_txcnt_final"},  32'(tx_count), 32'(NPKT));
   endtask

   initial begin
      logic [PKT_W-1:0] w;
      logic [ADDR_SZ-1:0] dst;
      int pl;
      reset        = 1'b0;
      id           = MY_ID;
      dest_cfg     = 4'd0;
      start        = 1'b0;
      channel_busy = 1'b0;
      lb           = 1'b0;
      rx_item      = {PKT_W{1'b0}};
      rx_valid     = 1'b0;
      model_reset();

      // Reset state
      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b1;

      // Reset arriving mid-run aborts it
      run_tx(4'd1, 0, -1, 3, "abort");

      // Free channel run
      run_tx(4'd1, 0, -1, -1, "free");

      // Back-pressure on packet 2 for 5 cycles
      run_tx(4'd1, 0, 2, -1, "bp");

      // Random back-pressure, random destination
      run_tx(ADDR_SZ'($urandom_range(15)), 50, -1, -1, "rndbp");

      // Loopback through the RX checker
      do_reset();
      lb = 1'b1;
      run_tx(MY_ID, 30, -1, -1, "loop");
      chk("loop_rxcnt",  32'(rx_count),   32'd8);
      chk("loop_parerr", 32'(parity_err), 32'd0);
      chk("loop_seqerr", 32'(seq_err),    32'd0);
      lb = 1'b0;

      // Parity fault
      do_reset();
      send_rx(mk(0, MY_ID), "par0");
      send_rx(mk(1, MY_ID), "par1");
      w = mk(2, MY_ID);
      w[PAR_BIT] = ~w[PAR_BIT];
      send_rx(w, "parbad");
      chk("parbad_flag",  32'(parity_err), 32'd1);
      chk("parbad_count", 32'(rx_count),   32'd2);
      send_rx(mk(2, MY_ID), "parnext");
      chk("parnext_noseq", 32'(seq_err), 32'd0);

      // Sequence gap and foreign address
      do_reset();
      send_rx(mk(0, MY_ID), "seq0");
      send_rx(mk(1, MY_ID), "seq1");
      send_rx(mk(3, MY_ID), "seq3");
      chk("seq_flag", 32'(seq_err),       32'd1);
      chk("seq_exp",  32'(dut.u_rx.exp_q), 32'd4);
      send_rx(mk(5, 4'd2), "foreign");
      chk("foreign_count", 32'(rx_count), 32'd3);
      send_rx(mk(4, MY_ID), "seq4");

      // Random RX traffic
      do_reset();
      for (int i = 0; i < 150; i++) begin
         dst = ($urandom_range(3) == 0) ? 4'd2 : MY_ID;
         if ($urandom_range(3) == 0)      pl = int'($urandom_range(PMASK));
         else if ($urandom_range(5) == 0) pl = 0;
         else                             pl = m_exp;
         w = mk(pl, dst);
         if ($urandom_range(7) == 0) w[PAR_BIT] = ~w[PAR_BIT];
         send_rx(w, "rndrx");
         if ($urandom_range(1) == 0) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
